// File: rtl/lu_op_sequencer_pkg.sv
// Shared encodings and defaults for the logical-unit operation sequencer.
package lu_op_sequencer_pkg;

    localparam int SECOND         = 100_000_000;
    localparam int EXEC_WAIT_DEF  = 4;
    localparam int TIMEOUT_DEF    = SECOND;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/lu_op_sequencer_if.sv
// Board/logical-unit side signals of the sequencer; master is the sequencer itself.
interface lu_op_sequencer_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       sw;
    logic             btn_next;
    logic             btn_cancel;
    logic [3:0]       lu_res;
    logic [3:0]       lu_operand1;
    logic [3:0]       lu_operand2;
    logic [1:0]       lu_selector;
    logic [3:0]       result;
    logic             result_valid;
    logic [2:0]       phase;
    logic [CNT_W-1:0] op_count;

    modport master (
        input  sw, btn_next, btn_cancel, lu_res,
        output lu_operand1, lu_operand2, lu_selector,
               result, result_valid, phase, op_count
    );

    modport slave (
        output sw, btn_next, btn_cancel, lu_res,
        input  lu_operand1, lu_operand2, lu_selector,
               result, result_valid, phase, op_count
    );
endinterface

// File: rtl/lu_op_sequencer_rise_pulse.sv
// One-cycle pulse on a registered 0->1 transition of a debounced level.
module rise_pulse #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic [1:0] hist;

    // History resets high so a button held through reset never fires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist <= {2{RST_VAL}};
        end else begin
            hist <= {hist[0], level};
        end
    end

    assign pulse = hist[0] & ~hist[1];
endmodule

// File: rtl/lu_op_sequencer.sv
// Sequences operand/selector loading into the 4-bit logical unit and captures its result.
//   state   | meaning
//   LOAD_A  | waiting for next press to latch operand A from sw
//   LOAD_B  | waiting for next press to latch operand B from sw
//   LOAD_OP | waiting for next press to latch selector from sw[1:0]
//   EXEC    | inputs held stable EXEC_WAIT cycles, then result captured
//   SHOW    | result displayed until next press or timeout
module lu_op_sequencer
    import lu_op_sequencer_pkg::*;
#(
    parameter int EXEC_WAIT      = EXEC_WAIT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input logic                clock,
    input logic                reset,
    lu_op_sequencer_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0]    EW_LAST = 4'(EXEC_WAIT - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [3:0]       operand1_q;
    logic [3:0]       operand2_q;
    logic [1:0]       selector_q;
    logic [3:0]       result_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       wait_cnt;
    logic [TW-1:0]    timeout_cnt;
    logic             next_p;
    logic             cancel_p;

    rise_pulse #(.RST_VAL(1'b1)) u_next (
        .clock (clock),
        .reset (reset),
        .level (bus.btn_next),
        .pulse (next_p)
    );

    rise_pulse #(.RST_VAL(1'b1)) u_cancel (
        .clock (clock),
        .reset (reset),
        .level (bus.btn_cancel),
        .pulse (cancel_p)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= LOAD_A;
            operand1_q  <= '0;
            operand2_q  <= '0;
            selector_q  <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
        end else if (cancel_p) begin
            // Cancel outranks both next and the EXEC capture.
            state   <= LOAD_A;
            valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (next_p) begin
                        operand1_q <= bus.sw;
                        state      <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (next_p) begin
                        operand2_q <= bus.sw;
                        state      <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (next_p) begin
                        selector_q <= bus.sw[1:0];
                        wait_cnt   <= '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == EW_LAST) begin
                        result_q    <= bus.lu_res;
                        count_q     <= count_q + 1'b1;
                        timeout_cnt <= '0;
                        valid_q     <= 1'b1;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (next_p || timeout_cnt == TO_LAST) begin
                        valid_q <= 1'b0;
                        state   <= LOAD_A;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= LOAD_A;
                end
            endcase
        end
    end

    assign bus.lu_operand1  = operand1_q;
    assign bus.lu_operand2  = operand2_q;
    assign bus.lu_selector  = selector_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.phase        = state;
    assign bus.op_count     = count_q;
endmodule
